// File: rtl/spi_mem_ctrl_gen2.sv
// SPI mode-0 memory master for instruction fetch and load/store traffic.
// Issues read (0x03) / write (0x02) of 1..MAX_BYTES bytes with a programmable SCLK divider.
module spi_mem_ctrl_gen2 #(
  parameter int ADDR_W    = 24,
  parameter int MAX_BYTES = 4,
  parameter int CLK_DIV   = 1,
  parameter int NB_W      = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   is_write,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [NB_W-1:0]        num_bytes,
  input  logic [8*MAX_BYTES-1:0] wdata,
  output logic [8*MAX_BYTES-1:0] rdata,
  output logic                   busy,
  output logic                   done,
  output logic                   sclk,
  output logic                   mosi,
  output logic                   cs_n,
  input  logic                   miso
);
  localparam int DBITS = 8 * MAX_BYTES;
  localparam int TX_W  = 8 + ADDR_W + DBITS;
  localparam int CW    = $clog2((ADDR_W > DBITS) ? ADDR_W : DBITS) + 1;
  localparam int DIVW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [DIVW-1:0]   div_q, div_d;
  logic [CW-1:0]     bit_q, bit_d;
  logic [TX_W-1:0]   tx_q, tx_d;
  logic [6:0]        rx_q, rx_d;
  logic [NB_W-1:0]   nb_q, nb_d;
  logic              wr_q, wr_d;
  logic [DBITS-1:0]  rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;

  logic [NB_W-1:0]   nb_eff;
  logic [TX_W-1:0]   frame;
  logic [CW-1:0]     last_bit;
  logic              half_end;

  // Whole frame is preloaded so CMD/ADDR/DATA shift out of one register.
  always_comb begin
    nb_eff = (num_bytes > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : num_bytes;
    frame = '0;
    frame[TX_W-1 -: 8] = is_write ? 8'h02 : 8'h03;
    frame[DBITS +: ADDR_W] = addr;
    if (is_write) begin
      for (int unsigned i = 0; i < MAX_BYTES; i++) begin
        frame[8*(MAX_BYTES-1-i) +: 8] = wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    case (state_q)
      S_CMD:   last_bit = CW'(7);
      S_ADDR:  last_bit = CW'(ADDR_W - 1);
      default: last_bit = CW'(8 * int'(nb_q) - 1);
    endcase
    half_end = (div_q == DIVW'(CLK_DIV - 1));
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    nb_d    = nb_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (nb_eff == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_CMD;
            cs_n_d  = 1'b0;
            sclk_d  = 1'b0;
            div_d   = '0;
            bit_d   = '0;
            rx_d    = '0;
            nb_d    = nb_eff;
            wr_d    = is_write;
            mosi_d  = frame[TX_W-1];
            tx_d    = frame << 1;
          end
        end
      end
      S_CMD, S_ADDR, S_DATA: begin
        if (!half_end) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            if (state_q == S_DATA && !wr_q) begin
              rx_d = {rx_q[5:0], miso};
              if (bit_q == '0) rdata_d = '0;
              if (bit_q[2:0] == 3'd7) begin
                for (int unsigned i = 0; i < MAX_BYTES; i++) begin
                  if (bit_q[CW-1:3] == (CW-3)'(i)) rdata_d[8*i +: 8] = {rx_q, miso};
                end
              end
            end
          end else begin
            mosi_d = tx_q[TX_W-1];
            tx_d   = tx_q << 1;
            if (bit_q == last_bit) begin
              bit_d = '0;
              case (state_q)
                S_CMD:  state_d = S_ADDR;
                S_ADDR: state_d = S_DATA;
                default: begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  cs_n_d  = 1'b1;
                  mosi_d  = 1'b0;
                end
              endcase
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      nb_q    <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      nb_q    <= nb_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sclk  = sclk_q;
  assign mosi  = mosi_q;
  assign cs_n  = cs_n_q;

endmodule

// File: tb/tb_spi_mem_ctrl_gen2.sv
// Scoreboard bench for spi_mem_ctrl_gen2: instance 0 uses CLK_DIV=1, instance 1 uses CLK_DIV=3.
// Each instance has an SPI slave model and a done-triggered monitor popping a shared queue.
module tb_spi_mem_ctrl_gen2;
  typedef struct {
    int unsigned inst;
    int unsigned t_done;
    logic [31:0] rdata;
    logic [63:0] cap;
    int unsigned rises;
    logic        cs_low;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_r    [2];
  logic        is_write_r [2];
  logic [23:0] addr_r     [2];
  logic [2:0]  nb_r       [2];
  logic [31:0] wdata_r    [2];
  logic [7:0]  resp       [2][4];

  exp_t sb_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, want 0x%0h", nm, cyc, act, exp_v);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int C = (g == 0) ? 1 : 3;
    logic [31:0] rdata_w;
    logic busy_w, done_w, sclk_w, mosi_w, cs_n_w;
    logic miso_r = 1'b0;
    logic prev_cs = 1'b1, prev_sclk = 1'b0, cs_fell = 1'b0, chk_busy = 1'b0;
    logic [63:0] cap = '0;
    int unsigned bitk = 0, rises = 0, run = 0, bad = 0, d = 0;
    logic [7:0] rb;
    exp_t e;

    spi_mem_ctrl_gen2 #(.ADDR_W(24), .MAX_BYTES(4), .CLK_DIV(C), .NB_W(3)) u_dut (
      .clk(clk), .rst(rst), .start(start_r[g]), .is_write(is_write_r[g]),
      .addr(addr_r[g]), .num_bytes(nb_r[g]), .wdata(wdata_r[g]), .rdata(rdata_w),
      .busy(busy_w), .done(done_w), .sclk(sclk_w), .mosi(mosi_w), .cs_n(cs_n_w), .miso(miso_r)
    );

    always @(negedge clk) begin
      if (rst) begin
        prev_cs = 1'b1;
        prev_sclk = 1'b0;
        chk_busy = 1'b0;
      end else begin
        if (chk_busy) begin
          chk($sformatf("busy_after_done[%0d]", g), busy_w, 0);
          chk_busy = 1'b0;
        end
        if (prev_cs && !cs_n_w) begin
          bitk = 0; cap = '0; rises = 0; cs_fell = 1'b1; run = 1; bad = 0; miso_r = 1'b0;
        end else if (!cs_n_w) begin
          if (sclk_w != prev_sclk) begin
            if (run != C) bad++;
            run = 1;
          end else begin
            run++;
          end
          if (!prev_sclk && sclk_w) begin
            cap = {cap[62:0], mosi_w};
            bitk++;
            rises++;
          end
          if (prev_sclk && !sclk_w) begin
            if (bitk >= 32 && bitk < 64) begin
              d = bitk - 32;
              rb = resp[g][d/8];
              miso_r = rb[7 - d%8];
            end else begin
              miso_r = 1'b0;
            end
          end
        end else if (!prev_cs && cs_n_w && run != C) begin
          bad++;
        end
        if (done_w) begin
          chk($sformatf("done_expected[%0d]", g), (sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk($sformatf("inst[%0d]", g), e.inst, g);
            chk($sformatf("done_cycle[%0d]", g), cyc, e.t_done);
            chk($sformatf("rdata[%0d]", g), rdata_w, e.rdata);
            chk($sformatf("mosi_bits[%0d]", g), cap, e.cap);
            chk($sformatf("sclk_rises[%0d]", g), rises, e.rises);
            chk($sformatf("cs_low_seen[%0d]", g), cs_fell, e.cs_low);
            chk($sformatf("sclk_phase_len[%0d]", g), bad, 0);
            chk($sformatf("busy_at_done[%0d]", g), busy_w, 1);
          end
          rises = 0; cap = '0; cs_fell = 1'b0; bad = 0; chk_busy = 1'b1;
        end
        prev_cs = cs_n_w;
        prev_sclk = sclk_w;
      end
    end
  end

  task automatic push_exp(input int unsigned g, input int unsigned t_done, input logic [31:0] rd,
                          input logic [63:0] cap, input int unsigned rises, input logic cs_low);
    exp_t e;
    e.inst = g; e.t_done = t_done; e.rdata = rd; e.cap = cap; e.rises = rises; e.cs_low = cs_low;
    sb_q.push_back(e);
  endtask

  task automatic issue(input int unsigned g, input logic w, input logic [23:0] a, input logic [2:0] n,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input int unsigned lat,
                       input logic [63:0] exp_cap, input int unsigned exp_rises, input logic exp_cs);
    is_write_r[g] = w; addr_r[g] = a; nb_r[g] = n; wdata_r[g] = wd; start_r[g] = 1'b1;
    push_exp(g, cyc + lat, exp_rd, exp_cap, exp_rises, exp_cs);
    @(negedge clk);
    start_r[g] = 1'b0;
  endtask

  task automatic set_resp(input int unsigned g, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    resp[g][0] = b0; resp[g][1] = b1; resp[g][2] = b2; resp[g][3] = b3;
  endtask

  task automatic wait_empty(input int unsigned limit);
    for (int unsigned i = 0; i < limit && sb_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("completion_in_budget", sb_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0;
    for (int i = 0; i < 2; i++) begin
      start_r[i] = 1'b0; is_write_r[i] = 1'b0; addr_r[i] = '0; nb_r[i] = '0; wdata_r[i] = '0;
      for (int j = 0; j < 4; j++) resp[i][j] = '0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", gen_dut[0].cs_n_w, 1);
    chk("rst_sclk", gen_dut[0].sclk_w, 0);
    chk("rst_mosi", gen_dut[0].mosi_w, 0);
    chk("rst_busy", gen_dut[0].busy_w, 0);
    chk("rst_done", gen_dut[0].done_w, 0);
    chk("rst_rdata", gen_dut[0].rdata_w, 0);
    chk("rst_cs_n_div3", gen_dut[1].cs_n_w, 1);
    rst = 1'b0;
    @(negedge clk);

    // Read 4 bytes at 0x000010
    set_resp(0, 8'h13, 8'h05, 8'h10, 8'h00);
    issue(0, 1'b0, 24'h000010, 3'd4, '0, 32'h00100513, 129, 64'h0300001000000000, 64, 1'b1);
    wait_empty(400);

    // Read 1 byte at 0x000123: upper bytes of previous rdata must clear
    set_resp(0, 8'hA5, 8'h00, 8'h00, 8'h00);
    issue(0, 1'b0, 24'h000123, 3'd1, '0, 32'h000000A5, 81, 64'h0000000300012300, 40, 1'b1);
    wait_empty(400);

    // Write 2 bytes: rdata must stay at the previous read value
    issue(0, 1'b1, 24'h0000FF, 3'd2, 32'h0000BEEF, 32'h000000A5, 97, 64'h0000020000FFEFBE, 48, 1'b1);
    wait_empty(400);

    // CLK_DIV=3, num_bytes=7 clamps to 4
    set_resp(1, 8'h13, 8'h05, 8'h10, 8'h00);
    issue(1, 1'b0, 24'h000010, 3'd7, '0, 32'h00100513, 385, 64'h0300001000000000, 64, 1'b1);
    wait_empty(1000);

    // CLK_DIV=3, read 2 bytes
    issue(1, 1'b0, 24'h000010, 3'd2, '0, 32'h00000513, 289, 64'h0000030000100000, 48, 1'b1);
    wait_empty(1000);

    // Reset at cycle 50 of a 4-byte read: no done, outputs return to idle at once
    set_resp(0, 8'h13, 8'h05, 8'h10, 8'h00);
    is_write_r[0] = 1'b0; addr_r[0] = 24'h000010; nb_r[0] = 3'd4; start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    repeat (49) @(negedge clk);
    chk("cs_low_before_rst", gen_dut[0].cs_n_w, 0);
    rst = 1'b1;
    #1;
    chk("midrst_cs_n", gen_dut[0].cs_n_w, 1);
    chk("midrst_sclk", gen_dut[0].sclk_w, 0);
    chk("midrst_busy", gen_dut[0].busy_w, 0);
    chk("midrst_rdata", gen_dut[0].rdata_w, 0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    issue(0, 1'b0, 24'h000010, 3'd4, '0, 32'h00100513, 129, 64'h0300001000000000, 64, 1'b1);
    wait_empty(400);

    // N=0: done in cycle 1, no SPI activity, rdata unchanged
    issue(0, 1'b0, 24'h000040, 3'd0, '0, 32'h00100513, 1, 64'h0, 0, 1'b0);
    wait_empty(20);

    // start pulsed while busy is ignored
    set_resp(0, 8'h5A, 8'h00, 8'h00, 8'h00);
    issue(0, 1'b0, 24'h000123, 3'd1, '0, 32'h0000005A, 81, 64'h0000000300012300, 40, 1'b1);
    repeat (8) @(negedge clk);
    is_write_r[0] = 1'b1; addr_r[0] = 24'hABCDEF; nb_r[0] = 3'd4; wdata_r[0] = 32'hFFFFFFFF;
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    wait_empty(300);
    repeat (150) @(negedge clk);

    // start held high: second read accepted the cycle after done
    is_write_r[0] = 1'b0; addr_r[0] = 24'h000123; nb_r[0] = 3'd1; wdata_r[0] = '0;
    start_r[0] = 1'b1;
    t0 = cyc;
    push_exp(0, t0 + 81, 32'h0000005A, 64'h0000000300012300, 40, 1'b1);
    push_exp(0, t0 + 163, 32'h000000C3, 64'h0000000300012300, 40, 1'b1);
    for (int unsigned i = 0; i < 500 && cyc < t0 + 83; i++) @(negedge clk);
    start_r[0] = 1'b0;
    resp[0][0] = 8'hC3;
    wait_empty(400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
